// File: rtl/serial_crc_receiver.sv
// Serial CRC-16 receiver: rebuilds an MSB-first payload, recomputes its CRC and checks the 16 trailing CRC bits.
// Optional saturating error counter, enabled by defining SERIAL_CRC_RX_ERR_COUNT_EN.
module serial_crc_receiver #(
    parameter int          DATA_WIDTH = 128,
    parameter logic [15:0] POLY       = 16'h1021,
    parameter logic [15:0] INIT       = 16'hFFFF,
    parameter logic [15:0] XOR_OUT    = 16'h0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  serial,
    input  logic                  enable,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [15:0]           crc_out,
    output logic                  valid,
    output logic                  crc_ok,
    output logic                  frame_err,
    output logic                  busy,
    output logic [7:0]            err_count
);
    // The counter must reach DATA_WIDTH-1 in DATA and 15 in CHECK.
    localparam int CW_MIN = $clog2(DATA_WIDTH + 1);
    localparam int CW     = (CW_MIN > 4) ? CW_MIN : 4;

    typedef enum logic [1:0] {IDLE, DATA, CHECK} state_t;

    state_t                state;
    logic [CW-1:0]         cnt;
    logic [15:0]           crc;
    logic [DATA_WIDTH-1:0] payload;
    logic [14:0]           rx_crc;
    logic [15:0]           rx_full;
    logic [15:0]           crc_final;
    logic [15:0]           crc_next;
    logic [DATA_WIDTH-1:0] payload_next;

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
        logic fb;
        fb = c[15] ^ b;
        return {c[14:0], 1'b0} ^ (fb ? POLY : 16'h0000);
    endfunction

    assign crc_next     = crc_step(crc, serial);
    assign payload_next = (payload << 1) | DATA_WIDTH'(serial);
    assign rx_full      = {rx_crc, serial};
    assign crc_final    = crc ^ XOR_OUT;
    assign busy         = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            crc       <= INIT;
            payload   <= '0;
            rx_crc    <= '0;
            data_out  <= '0;
            crc_out   <= '0;
            valid     <= 1'b0;
            crc_ok    <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            valid     <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable) begin
                        payload <= payload_next;
                        crc     <= crc_next;
                        if (DATA_WIDTH == 1) begin
                            state <= CHECK;
                            cnt   <= '0;
                        end else begin
                            state <= DATA;
                            cnt   <= CW'(1);
                        end
                    end
                end
                DATA: begin
                    if (enable) begin
                        payload <= payload_next;
                        crc     <= crc_next;
                        if (cnt == CW'(DATA_WIDTH - 1)) begin
                            state <= CHECK;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end else begin
                        state     <= IDLE;
                        cnt       <= '0;
                        crc       <= INIT;
                        frame_err <= 1'b1;
                    end
                end
                CHECK: begin
                    if (enable) begin
                        rx_crc <= rx_full[14:0];
                        if (cnt == CW'(15)) begin
                            data_out <= payload;
                            crc_out  <= crc_final;
                            crc_ok   <= (rx_full == crc_final);
                            valid    <= 1'b1;
                            crc      <= INIT;
                            cnt      <= '0;
                            state    <= IDLE;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end else begin
                        state     <= IDLE;
                        cnt       <= '0;
                        crc       <= INIT;
                        frame_err <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    crc   <= INIT;
                end
            endcase
        end
    end

`ifdef SERIAL_CRC_RX_ERR_COUNT_EN
    // Counts bad-CRC frames and aborted frames; sticks at 8'hFF.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_count <= 8'h00;
        end else if (((valid && !crc_ok) || frame_err) && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
        end
    end
`else
    assign err_count = 8'h00;
`endif

endmodule
